// File: rtl/lock_controller.sv
// Keypad lock controller: collects a four-digit BCD code, checks it on '#',
// and sequences the unlock hold, failure blink and lockout timer.
module lock_controller #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          MAX_FAILS      = 3,
    parameter int          OPEN_CYCLES    = 60_000_000,
    parameter int          LOCKOUT_CYCLES = 120_000_000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       done_blinking,
    output logic       unlocked,
    output logic       lockout,
    output logic       start_blinking,
    output logic       blink_type,
    output logic [2:0] digit_count
);

    localparam int CNT_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FW      = $clog2(MAX_FAILS + 1);
    localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_bstate;
    logic [3:0]      r_button;
    logic [15:0]     r_buf, w_buf;
    logic [2:0]      r_count, w_count;
    logic            r_ovf, w_ovf;
    logic [FW-1:0]   r_fail, w_fail, w_fail_inc;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_start, w_start;
    logic            r_btype, w_btype;
    logic            r_unlocked, r_lockout;
    logic            w_key_evt, w_match;

    // A key event fires on the cycle bstate is first seen low after being high.
    assign w_key_evt  = r_bstate & ~bstate;
    assign w_match    = (r_count == 3'd4) && !r_ovf && (r_buf == CODE);
    assign w_fail_inc = r_fail + FW'(1'b1);

    // Keypad sampling: latch the key while held, remember last bstate.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_bstate <= 1'b0;
            r_button <= 4'd0;
        end else begin
            r_bstate <= bstate;
            r_button <= bstate ? button : r_button;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        w_next_state = r_state;
        w_buf        = r_buf;
        w_count      = r_count;
        w_ovf        = r_ovf;
        w_fail       = r_fail;
        w_cnt        = r_cnt;
        w_start      = 1'b0;
        w_btype      = r_btype;
        case (r_state)
            S_ENTRY: begin
                if (w_key_evt && (r_button <= 4'd9)) begin
                    if (r_count == 3'd4) begin
                        w_ovf = 1'b1;
                    end else begin
                        w_buf   = {r_buf[11:0], r_button};
                        w_count = r_count + 3'd1;
                    end
                end else if (w_key_evt && (r_button == 4'd10)) begin
                    w_buf   = 16'd0;
                    w_count = 3'd0;
                    w_ovf   = 1'b0;
                end else if (w_key_evt && (r_button == 4'd11)) begin
                    w_next_state = S_CHECK;
                end else begin
                    w_next_state = S_ENTRY;
                end
            end
            S_CHECK: begin
                w_buf   = 16'd0;
                w_count = 3'd0;
                w_ovf   = 1'b0;
                if (w_match) begin
                    w_next_state = S_OPEN;
                    w_fail       = '0;
                    w_cnt        = OPEN_LOAD;
                    w_start      = 1'b1;
                    w_btype      = 1'b1;
                end else if (w_fail_inc == FAIL_LIMIT) begin
                    // Final strike goes straight to lockout with no blink request.
                    w_next_state = S_LOCKOUT;
                    w_fail       = w_fail_inc;
                    w_cnt        = LOCK_LOAD;
                end else begin
                    w_next_state = S_FAIL;
                    w_fail       = w_fail_inc;
                    w_start      = 1'b1;
                    w_btype      = 1'b0;
                end
            end
            S_OPEN: begin
                if (w_key_evt && (r_button == 4'd11)) begin
                    w_next_state = S_ENTRY;
                    w_cnt        = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = S_ENTRY;
                end else begin
                    w_cnt = r_cnt - CW'(1'b1);
                end
            end
            S_FAIL: begin
                // done_blinking during the request cycle belongs to an older sequence.
                if (!r_start && done_blinking) begin
                    w_next_state = S_ENTRY;
                end else begin
                    w_next_state = S_FAIL;
                end
            end
            S_LOCKOUT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_ENTRY;
                    w_fail       = '0;
                end else begin
                    w_cnt = r_cnt - CW'(1'b1);
                end
            end
            default: begin
                w_next_state = S_ENTRY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= S_ENTRY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_buf      <= 16'd0;
            r_count    <= 3'd0;
            r_ovf      <= 1'b0;
            r_fail     <= '0;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_btype    <= 1'b0;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_buf      <= w_buf;
            r_count    <= w_count;
            r_ovf      <= w_ovf;
            r_fail     <= w_fail;
            r_cnt      <= w_cnt;
            r_start    <= w_start;
            r_btype    <= w_btype;
            r_unlocked <= (w_next_state == S_OPEN);
            r_lockout  <= (w_next_state == S_LOCKOUT);
        end
    end

    assign unlocked       = r_unlocked;
    assign lockout        = r_lockout;
    assign start_blinking = r_start;
    assign blink_type     = r_btype;
    assign digit_count    = r_count;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios plus randomized entries,
// checked against a digit-queue model of the lock rules.
module tb_lock_controller;

    localparam int          OPEN_N = 20;
    localparam int          LOCK_N = 30;
    localparam int          MAXF   = 3;
    localparam logic [15:0] CODE_V = 16'h1234;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] button = 4'd0;
    logic       bstate = 1'b0;
    logic       done_blinking = 1'b0;
    logic       unlocked, lockout, start_blinking, blink_type;
    logic [2:0] digit_count;

    always #5 hwclk = ~hwclk;

    lock_controller #(
        .CODE(CODE_V), .MAX_FAILS(MAXF),
        .OPEN_CYCLES(OPEN_N), .LOCKOUT_CYCLES(LOCK_N)
    ) dut (
        .hwclk(hwclk), .reset(reset), .button(button), .bstate(bstate),
        .done_blinking(done_blinking), .unlocked(unlocked), .lockout(lockout),
        .start_blinking(start_blinking), .blink_type(blink_type),
        .digit_count(digit_count)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int model_q[$];
    int model_fails = 0;
    int exp_outcome = 0;   // 0 = unlock, 1 = failure blink, 2 = lockout
    int code_digits[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge hwclk);
    endtask

    task automatic press(input int k, input int hold);
        button = 4'(k);
        bstate = 1'b1;
        repeat (hold) tick();
        bstate = 1'b0;
        tick();
    endtask

    function automatic int exp_count();
        return (model_q.size() > 4) ? 4 : model_q.size();
    endfunction

    task automatic enter_key(input int k);
        press(k, $urandom_range(1, 3));
        if (k <= 9) model_q.push_back(k);
        else if (k == 10) model_q.delete();
        chk("entry_digit_count", digit_count, exp_count());
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic enter_keys(input int keys[$]);
        foreach (keys[i]) enter_key(keys[i]);
    endtask

    task automatic enter_code();
        for (int i = 0; i < 4; i++) enter_key(code_digits[i]);
    endtask

    // Press '#', check the single evaluation cycle, predict the outcome.
    task automatic submit();
        bit match;
        press(11, $urandom_range(1, 2));
        chk("check_unlocked", unlocked, 0);
        chk("check_start", start_blinking, 0);
        chk("check_lockout", lockout, 0);
        chk("check_digit_count", digit_count, exp_count());
        match = (model_q.size() == 4);
        for (int i = 0; i < model_q.size() && i < 4; i++)
            if (model_q[i] != code_digits[i]) match = 1'b0;
        model_q.delete();
        if (match) begin
            exp_outcome = 0;
            model_fails = 0;
        end else begin
            model_fails++;
            if (model_fails == MAXF) begin
                exp_outcome = 2;
                model_fails = 0;
            end else begin
                exp_outcome = 1;
            end
        end
        tick();
    endtask

    task automatic handle_open(input bit early);
        int v;
        chk("open_unlocked", unlocked, 1);
        chk("open_start", start_blinking, 1);
        chk("open_blink_type", blink_type, 1);
        chk("open_lockout", lockout, 0);
        chk("open_digit_count", digit_count, 0);
        if (early) begin
            repeat ($urandom_range(0, 5)) begin
                tick();
                chk("open_hold", unlocked, 1);
                chk("open_no_pulse", start_blinking, 0);
            end
            button = 4'd11;
            bstate = 1'b1;
            tick();
            chk("open_hash_held", unlocked, 1);
            bstate = 1'b0;
            tick();
            chk("open_hash_relock", unlocked, 0);
        end else begin
            for (int i = 1; i < OPEN_N; i++) begin
                if (i < OPEN_N - 3) begin
                    bstate = 1'($urandom_range(0, 1));
                    v = $urandom_range(0, 14);
                    if (v >= 11) v++;
                    button = 4'(v);
                end else begin
                    bstate = 1'b0;
                end
                tick();
                chk("open_hold", unlocked, 1);
                chk("open_no_pulse", start_blinking, 0);
            end
            tick();
            chk("open_expired", unlocked, 0);
            chk("open_expired_count", digit_count, 0);
        end
    endtask

    task automatic handle_fail();
        chk("fail_start", start_blinking, 1);
        chk("fail_blink_type", blink_type, 0);
        chk("fail_unlocked", unlocked, 0);
        chk("fail_lockout", lockout, 0);
        chk("fail_digit_count", digit_count, 0);
        done_blinking = 1'b1;
        tick();
        done_blinking = 1'b0;
        chk("fail_pulse_once", start_blinking, 0);
        press($urandom_range(0, 9), 1);
        chk("fail_key_ignored", digit_count, 0);
        repeat ($urandom_range(0, 3)) tick();
        done_blinking = 1'b1;
        tick();
        done_blinking = 1'b0;
        press($urandom_range(0, 9), 1);
        chk("after_fail_digit", digit_count, 1);
        press(10, 1);
        chk("after_fail_clear", digit_count, 0);
    endtask

    task automatic handle_lockout();
        chk("lock_lockout", lockout, 1);
        chk("lock_no_pulse", start_blinking, 0);
        chk("lock_blink_type_held", blink_type, 0);
        chk("lock_unlocked", unlocked, 0);
        for (int i = 1; i < LOCK_N; i++) begin
            if (i < LOCK_N - 3) begin
                bstate = 1'($urandom_range(0, 1));
                button = 4'($urandom_range(0, 15));
            end else begin
                bstate = 1'b0;
            end
            tick();
            chk("lock_hold", lockout, 1);
            chk("lock_no_pulse", start_blinking, 0);
            chk("lock_digit_count", digit_count, 0);
        end
        tick();
        chk("lock_expired", lockout, 0);
    endtask

    task automatic resolve(input bit early);
        case (exp_outcome)
            0:       handle_open(early);
            1:       handle_fail();
            default: handle_lockout();
        endcase
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_lockout"}, lockout, 0);
        chk({tag, "_start"}, start_blinking, 0);
        chk({tag, "_blink_type"}, blink_type, 0);
        chk({tag, "_digit_count"}, digit_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int keys[$];
        int mode;
        for (int i = 0; i < 4; i++)
            code_digits[i] = int'((CODE_V >> (12 - 4 * i)) & 16'h000F);

        // Reset values
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Correct code, full unlock period
        enter_code(); submit(); resolve(1'b0);

        // Short and long wrong entries
        keys = '{1, 2, 3};          enter_keys(keys); submit(); resolve(1'b0);
        keys = '{1, 2, 3, 4, 5};    enter_keys(keys); submit(); resolve(1'b0);
        enter_code(); submit(); resolve(1'b1);

        // Three strikes, then unlock after lockout
        for (int n = 0; n < MAXF; n++) begin
            keys = '{7, 7}; enter_keys(keys); submit(); resolve(1'b0);
        end
        enter_code(); submit(); resolve(1'b0);

        // Clear then correct code; '#' relocks early
        keys = '{9, 9, 10, 1, 2, 3, 4}; enter_keys(keys); submit(); resolve(1'b1);

        // Reset during OPEN
        enter_code(); submit();
        chk("pre_reset_open", unlocked, 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_values("reset_open");
        reset = 1'b0;
        tick();

        // Reset during LOCKOUT
        for (int n = 0; n < MAXF - 1; n++) begin
            keys = '{5}; enter_keys(keys); submit(); resolve(1'b0);
        end
        keys = '{5}; enter_keys(keys); submit();
        chk("pre_reset_lockout", lockout, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_reset_values("reset_lock");
        reset = 1'b0;
        tick();
        keys = '{5}; enter_keys(keys); submit(); resolve(1'b0);

        // Key held across reset, released with reset deassertion
        button = 4'd5; bstate = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; bstate = 1'b0;
        tick(); tick();
        chk("held_across_reset", digit_count, 0);

        // Key release coincident with reset
        button = 4'd6; bstate = 1'b1;
        tick(); tick();
        reset = 1'b1; bstate = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("release_during_reset", digit_count, 0);

        // Randomized entries
        repeat (16) begin
            keys.delete();
            mode = $urandom_range(0, 3);
            case (mode)
                0: for (int i = 0; i < 4; i++) keys.push_back(code_digits[i]);
                1: repeat ($urandom_range(0, 6)) keys.push_back($urandom_range(0, 9));
                2: begin
                    repeat ($urandom_range(1, 3)) keys.push_back($urandom_range(0, 9));
                    keys.push_back(10);
                    for (int i = 0; i < 4; i++) keys.push_back(code_digits[i]);
                end
                default: begin
                    for (int i = 0; i < 4; i++) keys.push_back(code_digits[i]);
                    keys.push_back($urandom_range(0, 9));
                end
            endcase
            if ($urandom_range(0, 3) == 0)
                keys.insert($urandom_range(0, keys.size()), $urandom_range(12, 15));
            enter_keys(keys);
            submit();
            resolve(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 SHALL have parameter CODE, default 16'h1234: four-digit unlock code, one BCD digit per nibble, first-entered digit in [15:12].
REQ-002 SHALL have parameter MAX_FAILS, default 3: number of consecutive wrong entries that triggers lockout.
REQ-003 SHALL have parameter OPEN_CYCLES, default 60_000_000: unlocked hold time, 5 s at 12 MHz.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 120_000_000: lockout duration, 10 s at 12 MHz.
REQ-005 SHALL have port hwclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port button, input, 4 bits: key code from the keypad scanner; 0-9 digit, 10 '*' (clear), 11 '#' (enter), 12-15 unused.
REQ-008 SHALL have port bstate, input, 1 bit: high while a key is held, synchronous to hwclk.
REQ-009 SHALL have port done_blinking, input, 1 bit: from the LED blinker, high when a blink sequence has finished.
REQ-010 SHALL have port unlocked, output, 1 bit: high only in OPEN.
REQ-011 SHALL have port lockout, output, 1 bit: high only in LOCKOUT.
REQ-012 SHALL have port start_blinking, output, 1 bit: one-cycle request pulse to the blinker.
REQ-013 SHALL have port blink_type, output, 1 bit: blinker pattern select; 1 means success, 0 means failure; valid with start_blinking.
REQ-014 SHALL have port digit_count, output, 3 bits: number of digits buffered, 0-4.

Function
REQ-015 SHALL register button on every cycle bstate=1 and register bstate delayed by one cycle.
REQ-016 SHALL generate one key event on the cycle after bstate goes from 1 to 0; the event carries the last registered button value.
REQ-017 SHALL use the states ENTRY, CHECK, OPEN, FAIL and LOCKOUT.
REQ-018 SHALL, in ENTRY on a digit event, shift the digit into a 16-bit buffer (buf <= {buf[11:0], digit}) and increment digit_count, saturating at 4.
REQ-019 SHALL set a sticky overflow flag on a digit event while digit_count=4; the buffer is left unchanged.
REQ-020 SHALL, in ENTRY on '*', clear buf, digit_count and overflow the next cycle.
REQ-021 SHALL, in ENTRY on '#', go to CHECK; codes 12-15 are ignored in every state.
REQ-022 SHALL spend exactly one cycle in CHECK; the entry matches only when digit_count=4 and overflow=0 and buf=CODE.
REQ-023 SHALL, from CHECK on a match: go to OPEN, clear fail_count, and pulse start_blinking with blink_type=1.
REQ-024 SHALL, from CHECK on a mismatch: increment fail_count; go to LOCKOUT when the new value equals MAX_FAILS; otherwise go to FAIL and pulse start_blinking with blink_type=0.
REQ-025 SHALL clear buf, digit_count and overflow on leaving CHECK, whichever branch is taken.
REQ-026 SHALL hold unlocked=1 throughout OPEN and load a down-counter with OPEN_CYCLES-1 on entry.
REQ-027 SHALL leave OPEN for ENTRY on a '#' event or when the OPEN counter reaches 0; digit and '*' events are ignored.
REQ-028 SHALL ignore all key events in FAIL and return to ENTRY on the first cycle after the pulse cycle in which done_blinking=1.
REQ-029 SHALL hold lockout=1 throughout LOCKOUT, ignore all key events, and load a down-counter with LOCKOUT_CYCLES-1 on entry.
REQ-030 SHALL, when the LOCKOUT counter reaches 0, go to ENTRY and clear fail_count.
REQ-031 SHALL drop any key event that falls in CHECK or in a state-transition cycle, with no deferred effect.
REQ-032 SHALL make start_blinking high for exactly one cycle per CHECK outcome and never in LOCKOUT; blink_type holds its last value otherwise.
REQ-033 SHALL size the counters to fit the largest parameter, with no wrap-around before reaching 0.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, set: state=ENTRY; buf=0; digit_count=0; overflow=0; fail_count=0; counters=0; unlocked=0; lockout=0; start_blinking=0; blink_type=0; registered bstate=0.
REQ-035 SHALL let reset take priority over every event, including mid-OPEN, mid-LOCKOUT and a coincident key release; no event is generated on the cycle after reset is released.

Verification
REQ-036 SHALL be verified with: keys 1,2,3,4,# -> one cycle of CHECK, start_blinking pulse with blink_type=1, unlocked=1 for OPEN_CYCLES, then ENTRY.
REQ-037 SHALL be verified with: keys 1,2,3,# and separately 1,2,3,4,5,# -> FAIL with blink_type=0; after done_blinking, ENTRY with digit_count=0.
REQ-038 SHALL be verified with: three wrong entries -> lockout=1 and no third blink pulse; keys ignored during LOCKOUT_CYCLES; afterwards 1,2,3,4,# unlocks.
REQ-039 SHALL be verified with: keys 9,9,*,1,2,3,4,# -> unlock; a '#' in OPEN relocks on the next cycle.
REQ-040 SHALL be verified with: reset asserted in OPEN and in LOCKOUT -> all outputs at reset values the next cycle; bstate held high across reset produces no event.
